// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: splits 32-bit loads/stores into two 16-bit async SRAM
// phases and freezes the pipeline until both halves complete.
module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;

  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [18:0] BASE = 19'(ADDR_BASE);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [18:0] offs;
  logic        last;
  logic        hi_ph;
  logic        unused_ok;

  // Low offset bits of a subtraction depend only on low operand bits.
  assign offs      = address[18:0] - BASE;
  assign last      = (cnt_q == LAST);
  assign hi_ph     = (state_q == HI);
  assign unused_ok = ^{address[31:19], offs[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state_q)
      IDLE: begin
        ready = ~(mem_read | mem_write);
        if (mem_read | mem_write) begin
          rd_d    = mem_read;
          idx_d   = offs[18:2];
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO, HI: begin
        sram_addr = {idx_q, hi_ph};
        if (rd_q) begin
          if (last) begin
            if (hi_ph) rdata_d[31:16] = sram_dq_in;
            else       rdata_d[15:0]  = sram_dq_in;
          end
        end else begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = hi_ph ? wdata_q[31:16] : wdata_q[15:0];
          // Last cycle of a phase releases we_n for address/data hold.
          sram_we_n   = (WAIT_CYCLES > 1) ? last : 1'b0;
        end
        if (last) begin
          cnt_d   = '0;
          state_d = hi_ph ? DONE : HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;
  assign freeze    = ~ready;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl at WAIT_CYCLES=3 and 1,
// with a behavioural async SRAM behind the 3-cycle instance.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd3 = 0, wr3 = 0;
  logic [31:0] addr3 = 0, wd3 = 0, rdata3;
  logic        rdy3, frz3, oe3, wen3;
  logic [17:0] sa3;
  logic [15:0] dqo3, dqi3;

  logic        rd1 = 0, wr1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0, rdata1;
  logic        rdy1, frz1, oe1, wen1;
  logic [17:0] sa1;
  logic [15:0] dqo1;
  logic [15:0] dqi1 = 16'hA5C3;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:262143];
  assign dqi3 = mem[sa3];
  always @(posedge clk) if (!wen3) mem[sa3] <= dqo3;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .mem_read(rd3), .mem_write(wr3),
    .address(addr3), .write_data(wd3), .read_data(rdata3),
    .ready(rdy3), .freeze(frz3), .sram_addr(sa3),
    .sram_dq_out(dqo3), .sram_dq_oe(oe3), .sram_dq_in(dqi3),
    .sram_we_n(wen3)
  );

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
    .address(addr1), .write_data(wd1), .read_data(rdata1),
    .ready(rdy1), .freeze(frz1), .sram_addr(sa1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1),
    .sram_we_n(wen1)
  );

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the 3-cycle DUT; returns one cycle after DONE.
  task automatic access3(input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [17:0] lo,
                         input logic [31:0] exp_rd, input string tag);
    int frz = 0;
    logic [15:0] hw;
    logic ewen;
    rd3 = rd; wr3 = ~rd; addr3 = a; wd3 = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy3) break;
      frz++;
      if (c >= 1 && c <= 6) begin
        hw   = (c <= 3) ? d[15:0] : d[31:16];
        ewen = rd | !(c == 1 || c == 2 || c == 4 || c == 5);
        expect_eq({tag, ":addr"}, 32'(sa3),
                  32'((c <= 3) ? lo : (lo | 18'd1)));
        expect_eq({tag, ":we_n"}, 32'(wen3), 32'(ewen));
        expect_eq({tag, ":oe"}, 32'(oe3), 32'(!rd));
        if (!rd) expect_eq({tag, ":dq"}, 32'(dqo3), 32'(hw));
      end
      @(posedge clk); #1;
    end
    expect_eq({tag, ":frozen"}, frz, 7);
    expect_eq({tag, ":frz_done"}, 32'(frz3), 0);
    if (rd) expect_eq({tag, ":rdata"}, rdata3, exp_rd);
    @(posedge clk); #1;
    rd3 = 0; wr3 = 0;
  endtask

  task automatic access1(input logic rd, input string tag);
    int frz = 0;
    int wel = 0;
    rd1 = rd; wr1 = ~rd; addr1 = 32'd1032; wd1 = 32'h0F0F1234;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rdy1) break;
      frz++;
      if (!wen1) wel++;
      @(posedge clk); #1;
    end
    expect_eq({tag, ":frozen"}, frz, 3);
    expect_eq({tag, ":we_low"}, wel, rd ? 0 : 2);
    if (rd) expect_eq({tag, ":rdata"}, rdata1, 32'hA5C3A5C3);
    @(posedge clk); #1;
    rd1 = 0; wr1 = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    expect_eq("rst:ready", 32'(rdy3), 1);
    expect_eq("rst:freeze", 32'(frz3), 0);
    expect_eq("rst:we_n", 32'(wen3), 1);
    expect_eq("rst:oe", 32'(oe3), 0);
    expect_eq("rst:rdata", rdata3, 0);
    expect_eq("rst:addr", 32'(sa3), 0);
    expect_eq("rst:ready1", 32'(rdy1), 1);
    @(posedge clk); #1;

    access3(0, 32'd1024, 32'hDEADBEEF, 18'd0, 0, "wr1024");
    access3(1, 32'd1024, 0, 18'd0, 32'hDEADBEEF, "rd1024");
    access3(0, 32'd1028, 32'h12345678, 18'd2, 0, "wr1028");
    expect_eq("hold_rdata", rdata3, 32'hDEADBEEF);
    access3(1, 32'd1031, 0, 18'd2, 32'h12345678, "rd1031");
    access3(0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 0, "wr1020");
    access3(1, 32'd1020, 0, 18'h3FFFE, 32'hCAFEF00D, "rd1020");
    access3(1, 32'd1024, 0, 18'd0, 32'hDEADBEEF, "rd1024b");

    // Reset while the high half of a write is in progress.
    rd3 = 0; wr3 = 1; addr3 = 32'd1024; wd3 = 32'h55555555;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("mid:hi_addr", 32'(sa3), 1);
    expect_eq("mid:freeze", 32'(frz3), 1);
    rst = 1; wr3 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    expect_eq("rstmid:ready", 32'(rdy3), 1);
    expect_eq("rstmid:we_n", 32'(wen3), 1);
    expect_eq("rstmid:oe", 32'(oe3), 0);
    expect_eq("rstmid:rdata", rdata3, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    expect_eq("post:ready", 32'(rdy3), 1);
    @(posedge clk); #1;

    access1(1, "w1rd_a");
    access1(0, "w1wr_a");
    access1(1, "w1rd_b");
    access1(0, "w1wr_b");
    expect_eq("w1:hold", rdata1, 32'hA5C3A5C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage responder for the load/store requests issued by instruction decode (mem_read for LDR, mem_write for STR).
- Converts each 32-bit word access into two 16-bit accesses on an external asynchronous SRAM.
- Holds the pipeline with freeze until the access completes.
- Sits between the EXE/MEM pipeline register and the MEM/WB register.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: clock cycles per 16-bit SRAM phase; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  load request, level, held by the pipeline until ready
- mem_write  input  1  store request, level, held by the pipeline until ready
- address  input  32  byte address from ALU
- write_data  input  32  store data (Rd value)
- read_data  output  32  load result; valid when ready=1 after a read
- ready  output  1  access complete, or no access pending
- freeze  output  1  equals ~ready; stalls all upstream pipeline registers
- sram_addr  output  18  SRAM half-word address
- sram_dq_out  output  16  data driven to SRAM
- sram_dq_oe  output  1  tristate enable for sram_dq_out (top level builds the inout)
- sram_dq_in  input  16  data from SRAM
- sram_we_n  output  1  active-low SRAM write enable

Behaviour:
- Reset (clk and rst as named above; reset is synchronous and active-high):
  - state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping:
  - idx = (address - ADDR_BASE)[18:2], modulo arithmetic; below-base addresses wrap.
  - address[1:0] is ignored; no alignment fault.
  - Low half is at sram_addr={idx,1'b0}, high half at {idx,1'b1}.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(mem_read | mem_write).
  - On a request, latch address, write_data and op (read if mem_read=1, even when both are asserted; both asserted is illegal and performs no write). Go to LO with counter=0.
  - No request: all SRAM outputs idle (we_n=1, oe=0).
- LO:
  - sram_addr low-half address.
  - On a write: oe=1, dq_out=wdata[15:0], and we_n=0 while counter < WAIT_CYCLES-1. we_n=1 on the last cycle, giving address/data hold; with WAIT_CYCLES=1, we_n is low for that one cycle.
  - On a read: oe=0, we_n=1, and sram_dq_in is captured into read_data[15:0] on the last cycle (counter==WAIT_CYCLES-1).
  - After WAIT_CYCLES cycles go to HI, counter=0.
- HI: identical to LO using the high-half address and bits [31:16]. After WAIT_CYCLES cycles go to DONE.
- DONE:
  - ready=1 for exactly one cycle; SRAM outputs idle. Next state is IDLE.
  - The pipeline advances on this edge, so the inputs sampled in the following IDLE cycle belong to the next instruction.
- Latency:
  - Request first seen in cycle 0.
  - freeze=1 for cycles 0..2*WAIT_CYCLES; ready=1 in cycle 2*WAIT_CYCLES+1.
  - With WAIT_CYCLES=3: 7 frozen cycles.
- read_data:
  - Updates only on read phases; holds its value across writes and idle cycles.
  - Low half may be updated before the high half; the value is valid only when ready=1 in DONE.
- Inputs are ignored outside IDLE; the latched copies are used.
- Reset in any state returns to IDLE on that edge with reset values. An interrupted write may leave one half written; this is accepted.
- No request: ready=1, freeze=0, zero SRAM activity.

Test Plan:
- Reset with no request -> ready=1, freeze=0, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write address=1024, data=0xDEADBEEF, WAIT_CYCLES=3:
  - sram_addr=0 with dq_out=0xBEEF for 3 cycles, then sram_addr=1 with dq_out=0xDEAD for 3 cycles.
  - we_n low 2 cycles per phase.
  - freeze high 7 cycles, ready=1 in cycle 7.
- Read address=1024 against a behavioural SRAM model holding the previous write -> read_data=0xDEADBEEF when ready=1, sram_we_n never low.
- Address mapping:
  - address=1028 -> sram_addr 2 then 3.
  - address=1031 -> same 2, 3.
  - address=1020 -> 0x3FFFE then 0x3FFFF (wrap).
- Reset during HI of a write -> next cycle state IDLE, we_n=1, oe=0, read_data=0, ready=1 when no request.
- Back-to-back read then write (requests change on the DONE edge) -> second access starts the cycle after DONE with no extra idle cycle. Repeat with WAIT_CYCLES=1 -> freeze exactly 3 cycles per access.
